mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single tiny16 memory port between NREQ bus masters: port 0 is the CPU controller (fetch/indirect operand); ports 1..NREQ-1 are DMA/IO/video masters.
// - Arbitrates, latches one transaction, drives the memory for 1+WAIT_STATES cycles, then returns read data with a one-cycle ack.
// - Sits between the controller/peripherals and the memory module.
// PARAMETERS
// - NREQ         4   number of requesters (2..8)
// - AW           16  address width
// - DW           16  data width
// - WAIT_STATES  0   extra memory cycles per access (0..15)
// - CPU_PRIO     1   1: req[0] always wins; 0: port 0 joins the round-robin
// PORTS
// - clk        in   1        clock, all state on rising edge
// - rst        in   1        asynchronous, active-low reset
// - req        in   NREQ     access request per port, held until ack
// - lock       in   NREQ     keep the grant for the next access (read-modify-write)
// - we         in   NREQ     1 = write, 0 = read
// - addr       in   NREQ*AW  flattened addresses, port i at [i*AW +: AW]
// - wdata      in   NREQ*DW  flattened write data, port i at [i*DW +: DW]
// - gnt        out  NREQ     one-hot owner of the current transaction
// - ack        out  NREQ     one-cycle completion pulse to owner
// - rdata      out  DW       read data, valid in the ack cycle
// - mem_en     out  1        memory access strobe
// - mem_we     out  1        memory write enable
// - mem_addr   out  AW       memory address
// - mem_wdata  out  DW       memory write data
// - mem_rdata  in   DW       memory read data, valid at end of each access cycle
// - busy       out  1        transaction in progress (state != IDLE)
// BEHAVIOUR
// - Reset values: gnt=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, state=IDLE, rr_ptr=0, lock_owner=none.
// - FSM IDLE -> ACCESS -> (WAIT x WAIT_STATES) -> DONE -> IDLE.
// - IDLE, any req: pick winner; latch idx, addr, wdata, we; set gnt[idx]; go ACCESS. No req: stay in IDLE with all outputs 0.
// - Winner selection order: (1) locked owner, if it still asserts req; (2) req[0], if CPU_PRIO=1; (3) first requester at or after rr_ptr, wrapping NREQ-1 -> 0.
// - ACCESS/WAIT: mem_en=1, mem_addr/mem_wdata = latched values, mem_we = latched we. Values stay stable across all WAIT cycles.
// - WAIT count: 4-bit down-counter loaded with WAIT_STATES on the ACCESS entry.
// - mem_rdata capture: last ACCESS/WAIT cycle latches mem_rdata into rdata (reads only; writes leave rdata unchanged).
// - DONE: ack[idx]=1 for exactly one cycle; gnt[idx] stays high; mem_en=0. Update rr_ptr to (idx+1) mod NREQ. Set lock_owner=idx if lock[idx], else clear it.
// - DONE -> IDLE always, so arbitration latency is 1 cycle.
// - Timing at WAIT_STATES=0: req sampled at edge N; ack at edge N+2; next grant at N+3 at the earliest.
// - gnt clears on IDLE entry.
// - req dropped mid-transaction: the latched access still completes and ack still pulses; a requester may not abort.
// - req/addr changes by the owner after latching are ignored until ack.
// - Simultaneous requests: exactly one gnt bit set; the others wait.
// - Fairness: with CPU_PRIO=0, no port waits more than NREQ-1 transactions. With CPU_PRIO=1, continuous req[0] may starve others (documented).
// - lock with req low in IDLE: lock_owner is cleared and normal arbitration applies.
// - Reset mid-transaction: abort immediately with no ack; memory write may be partial (system-level concern).
// - Protocol: at most one mem_en burst per transaction; mem_we is never high while mem_en is low.
// STRUCTURE
// - Package tiny16_bus_pkg: state enum (IDLE, ACCESS, WAIT, DONE), AW/DW defaults, NREQ_MAX=8.
// - Sub-module rr_picker: combinational, (req, rr_ptr, prio_en) -> one-hot winner plus index. Reused by a future interrupt controller.
// - Top: FSM, latch registers, wait counter, rr_ptr, lock_owner.
// TESTING
// 1. Single read, port 1, addr 0x0040, mem=0xBEEF, WAIT_STATES=0 -> mem_en at cycle 1; ack[1] and rdata=0xBEEF at cycle 2; busy low at cycle 3.
// 2. req=4'b1110, CPU_PRIO=0, held -> grant order 1,2,3,1,2,3; each ack 3 cycles apart.
// 3. req=4'b1011, CPU_PRIO=1 -> port 0 wins every arbitration; drop req[0] -> ports 1 then 3 served.
// 4. Port 2 write 0x1234 @0x0100 with lock=1, then read same addr while port 1 requests -> port 2 regranted; rdata=0x1234; port 1 served next.
// 5. WAIT_STATES=3 -> mem_en high 4 cycles with stable addr; ack 5 cycles after sampling.
// 6. Assert rst during WAIT -> all outputs 0 next edge, no ack; after release, pending req restarts from rr_ptr=0.

Source files
------------

// File: rtl/tiny16_bus_pkg.sv
// Shared tiny16 bus definitions: arbiter state encoding and default widths.
package tiny16_bus_pkg;

    localparam int unsigned AW_DEF   = 16;
    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned WCNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational request picker.
//   req       - request vector
//   rr_ptr    - round-robin start position (must be < NREQ)
//   prio_en   - when set, req[0] wins outright
//   win_c     - one-hot winner (zero when no request)
//   win_idx_c - index of the winner
//   valid_c   - at least one request present
module rr_picker
    import tiny16_bus_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            prio_en,
    output logic [NREQ-1:0] win_c,
    output logic [IW-1:0]   win_idx_c,
    output logic            valid_c
);

    // Scan from rr_ptr upward, wrapping NREQ-1 -> 0; first hit wins.
    always_comb begin
        int unsigned pos;
        win_c     = '0;
        win_idx_c = '0;
        valid_c   = 1'b0;
        pos       = 0;
        if (prio_en && req[0]) begin
            win_c[0] = 1'b1;
            valid_c  = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                pos = 32'(rr_ptr) + i;
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                if (!valid_c && req[IW'(pos)]) begin
                    win_c[IW'(pos)] = 1'b1;
                    win_idx_c       = IW'(pos);
                    valid_c         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single tiny16 memory port among NREQ masters.
// Port 0 is the CPU controller; the rest are DMA/IO/video masters.
// One transaction at a time: IDLE -> ACCESS -> WAIT x WAIT_STATES -> DONE.
//   clk, rst           - clock, asynchronous active-low reset
//   req/lock/we        - per-port request, grant-keep, write flag
//   addr/wdata         - flattened per-port address / write data
//   gnt/ack/rdata      - owner one-hot, one-cycle completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory-side port
//   busy               - a transaction is in progress
module mem_arbiter
    import tiny16_bus_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          CPU_PRIO    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic [DW-1:0]    rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                lock_valid_q, lock_valid_d;
    logic [IW-1:0]       lock_idx_q, lock_idx_d;

    logic [NREQ-1:0]     gnt_d, ack_d;
    logic [DW-1:0]       rdata_d;
    logic                mem_en_d, mem_we_d, busy_d;
    logic [AW-1:0]       mem_addr_d;
    logic [DW-1:0]       mem_wdata_d;

    logic [NREQ-1:0]     pick_win_c;
    logic [IW-1:0]       pick_idx_c;
    logic                pick_valid_c;
    logic                lock_hit_c;
    logic [IW-1:0]       sel_idx_c;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .prio_en   (CPU_PRIO),
        .win_c     (pick_win_c),
        .win_idx_c (pick_idx_c),
        .valid_c   (pick_valid_c)
    );

    // A locked owner that is still requesting beats both CPU priority and round-robin.
    assign lock_hit_c = lock_valid_q && req[lock_idx_q];
    assign sel_idx_c  = lock_hit_c ? lock_idx_q : pick_idx_c;

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        wcnt_d       = wcnt_q;
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        gnt_d        = gnt;
        ack_d        = '0;
        rdata_d      = rdata;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        busy_d       = busy;

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                // Lock is forfeited as soon as its owner stops requesting in IDLE.
                if (lock_valid_q && !req[lock_idx_q]) begin
                    lock_valid_d = 1'b0;
                end
                if (pick_valid_c) begin
                    state_d     = ACCESS;
                    idx_d       = sel_idx_c;
                    addr_d      = addr[32'(sel_idx_c) * AW +: AW];
                    wdata_d     = wdata[32'(sel_idx_c) * DW +: DW];
                    we_d        = we[sel_idx_c];
                    wcnt_d      = WCNT_W'(WAIT_STATES);
                    busy_d      = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[sel_idx_c];
                    mem_addr_d  = addr[32'(sel_idx_c) * AW +: AW];
                    mem_wdata_d = wdata[32'(sel_idx_c) * DW +: DW];
                    if (lock_hit_c) begin
                        gnt_d             = '0;
                        gnt_d[lock_idx_q] = 1'b1;
                    end else begin
                        gnt_d = pick_win_c;
                    end
                end
            end

            ACCESS, WAIT: begin
                busy_d = 1'b1;
                if (wcnt_q == '0) begin
                    // Last memory cycle: capture read data and close the transaction.
                    state_d      = DONE;
                    ack_d[idx_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    rr_ptr_d     = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                    lock_valid_d = lock[idx_q];
                    lock_idx_d   = idx_q;
                end else begin
                    state_d     = WAIT;
                    wcnt_d      = wcnt_q - WCNT_W'(1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end
            end

            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched transaction and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            wcnt_q       <= '0;
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            gnt          <= '0;
            ack          <= '0;
            rdata        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            wcnt_q       <= wcnt_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            gnt          <= gnt_d;
            ack          <= ack_d;
            rdata        <= rdata_d;
            mem_en       <= mem_en_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin / zero wait states and
// CPU-priority / three wait states) driven by random masters and checked
// every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int          NK   = 2;
    localparam int          NR   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_k       [NK] = '{default: 1'b0};
    logic [NREQ-1:0]    req_k       [NK] = '{default: '0};
    logic [NREQ-1:0]    lock_k      [NK] = '{default: '0};
    logic [NREQ-1:0]    we_k        [NK] = '{default: '0};
    logic [NREQ*AW-1:0] addr_k      [NK] = '{default: '0};
    logic [NREQ*DW-1:0] wdata_k     [NK] = '{default: '0};
    logic [NREQ-1:0]    gnt_k       [NK];
    logic [NREQ-1:0]    ack_k       [NK];
    logic [DW-1:0]      rdata_k     [NK];
    logic               mem_en_k    [NK];
    logic               mem_we_k    [NK];
    logic [AW-1:0]      mem_addr_k  [NK];
    logic [DW-1:0]      mem_wdata_k [NK];
    logic [DW-1:0]      mem_rdata_k [NK];
    logic               busy_k      [NK];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_STATES(0), .CPU_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst_k[0]), .req(req_k[0]), .lock(lock_k[0]), .we(we_k[0]),
        .addr(addr_k[0]), .wdata(wdata_k[0]), .gnt(gnt_k[0]), .ack(ack_k[0]),
        .rdata(rdata_k[0]), .mem_en(mem_en_k[0]), .mem_we(mem_we_k[0]),
        .mem_addr(mem_addr_k[0]), .mem_wdata(mem_wdata_k[0]),
        .mem_rdata(mem_rdata_k[0]), .busy(busy_k[0]));

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_STATES(3), .CPU_PRIO(1'b1)) dut_cp (
        .clk(clk), .rst(rst_k[1]), .req(req_k[1]), .lock(lock_k[1]), .we(we_k[1]),
        .addr(addr_k[1]), .wdata(wdata_k[1]), .gnt(gnt_k[1]), .ack(ack_k[1]),
        .rdata(rdata_k[1]), .mem_en(mem_en_k[1]), .mem_we(mem_we_k[1]),
        .mem_addr(mem_addr_k[1]), .mem_wdata(mem_wdata_k[1]),
        .mem_rdata(mem_rdata_k[1]), .busy(busy_k[1]));

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit prio_of(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [DW-1:0] init_val(input int a);
        return 16'hA000 ^ 16'(a * 16'h1357);
    endfunction

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory attached to each arbiter: 16 words, aliased on addr[3:0].
    logic [DW-1:0] mem_k [NK][16];
    bit            mem_ready = 1'b0;
    assign mem_rdata_k[0] = mem_k[0][mem_addr_k[0][3:0]];
    assign mem_rdata_k[1] = mem_k[1][mem_addr_k[1][3:0]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < NK; k++)
                for (int a = 0; a < 16; a++)
                    mem_k[k][a] <= init_val(a);
            mem_ready <= 1'b1;
        end else begin
            for (int k = 0; k < NK; k++)
                if (mem_en_k[k] && mem_we_k[k])
                    mem_k[k][mem_addr_k[k][3:0]] <= mem_wdata_k[k];
        end
    end

    // Random masters: request, hold until ack, sometimes abort or wiggle addr while owner.
    bit pend [NK][NREQ] = '{default: 1'b0};
    int rate = 0;

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rst_k[k]) begin
                    if (pend[k][i] && !req_k[k][i]) pend[k][i] = 1'b0;
                end else if (pend[k][i]) begin
                    if (ack_k[k][i]) begin
                        pend[k][i]  = 1'b0;
                        req_k[k][i] = 1'b0;
                    end else if (gnt_k[k][i]) begin
                        if ($urandom_range(9) == 0) req_k[k][i] = 1'b0;
                        if ($urandom_range(3) == 0) addr_k[k][i*AW +: AW] = 16'($urandom);
                    end
                end
                if (rst_k[k] && !pend[k][i] && $urandom_range(99) < 32'(rate)) begin
                    pend[k][i]             = 1'b1;
                    req_k[k][i]            = 1'b1;
                    we_k[k][i]             = 1'($urandom);
                    lock_k[k][i]           = ($urandom_range(3) == 0);
                    addr_k[k][i*AW +: AW]  = 16'($urandom);
                    wdata_k[k][i*DW +: DW] = 16'($urandom);
                end
            end
        end
    end

    // Reference model: one transaction occupies 1+WS memory cycles plus one ack
    // cycle, then one idle cycle before the next arbitration.
    int            m_t     [NK];
    int            m_idx   [NK];
    bit            m_we    [NK];
    logic [AW-1:0] m_addr  [NK];
    logic [DW-1:0] m_wdata [NK];
    logic [DW-1:0] m_rdata [NK];
    int            m_rr    [NK];
    bit            m_lockv [NK];
    int            m_locki [NK];
    logic [DW-1:0] ref_mem [NK][16];
    bit            ref_ready = 1'b0;

    always @(posedge clk) begin
        if (!ref_ready) begin
            for (int k = 0; k < NK; k++)
                for (int a = 0; a < 16; a++)
                    ref_mem[k][a] = init_val(a);
            ref_ready = 1'b1;
        end
        for (int k = 0; k < NK; k++) begin
            int ws;
            int w;
            ws = ws_of(k);
            if (!rst_k[k]) begin
                m_t[k] = -1; m_idx[k] = 0; m_rr[k] = 0;
                m_lockv[k] = 1'b0; m_locki[k] = 0; m_rdata[k] = '0;
            end else if (m_t[k] < 0) begin
                if (m_lockv[k] && !req_k[k][m_locki[k]]) m_lockv[k] = 1'b0;
                w = -1;
                if (m_lockv[k]) begin
                    w = m_locki[k];
                end else if (prio_of(k) && req_k[k][0]) begin
                    w = 0;
                end else begin
                    for (int n = 0; n < NR; n++) begin
                        int j;
                        j = (m_rr[k] + n) % NR;
                        if (w < 0 && req_k[k][j]) w = j;
                    end
                end
                if (w >= 0) begin
                    m_t[k]     = 0;
                    m_idx[k]   = w;
                    m_we[k]    = we_k[k][w];
                    m_addr[k]  = addr_k[k][w*AW +: AW];
                    m_wdata[k] = wdata_k[k][w*DW +: DW];
                end
            end else if (m_t[k] <= ws) begin
                if (m_we[k]) ref_mem[k][m_addr[k][3:0]] = m_wdata[k];
                else if (m_t[k] == ws) m_rdata[k] = ref_mem[k][m_addr[k][3:0]];
                if (m_t[k] == ws) begin
                    m_rr[k]    = (m_idx[k] + 1) % NR;
                    m_lockv[k] = lock_k[k][m_idx[k]];
                    m_locki[k] = m_idx[k];
                end
                m_t[k]++;
            end else begin
                m_t[k] = -1;
            end
        end

        #1;
        for (int k = 0; k < NK; k++) begin
            logic [NREQ-1:0] e_gnt, e_ack;
            logic            e_en, e_we, e_busy;
            logic [AW-1:0]   e_addr;
            logic [DW-1:0]   e_wd;
            e_gnt = '0; e_ack = '0; e_en = 1'b0; e_we = 1'b0;
            e_busy = 1'b0; e_addr = '0; e_wd = '0;
            if (m_t[k] >= 0) begin
                e_gnt  = NREQ'(1) << m_idx[k];
                e_busy = 1'b1;
                if (m_t[k] <= ws_of(k)) begin
                    e_en = 1'b1; e_we = m_we[k]; e_addr = m_addr[k]; e_wd = m_wdata[k];
                end else begin
                    e_ack = e_gnt;
                end
            end
            check($sformatf("k%0d gnt", k),       32'(gnt_k[k]),       32'(e_gnt));
            check($sformatf("k%0d ack", k),       32'(ack_k[k]),       32'(e_ack));
            check($sformatf("k%0d busy", k),      32'(busy_k[k]),      32'(e_busy));
            check($sformatf("k%0d mem_en", k),    32'(mem_en_k[k]),    32'(e_en));
            check($sformatf("k%0d mem_we", k),    32'(mem_we_k[k]),    32'(e_we));
            check($sformatf("k%0d mem_addr", k),  32'(mem_addr_k[k]),  32'(e_addr));
            check($sformatf("k%0d mem_wdata", k), 32'(mem_wdata_k[k]), 32'(e_wd));
            check($sformatf("k%0d rdata", k),     32'(rdata_k[k]),     32'(m_rdata[k]));
        end
    end

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        rst_k[0] = 1'b1;
        rst_k[1] = 1'b1;

        rate = 90;
        repeat (1500) @(negedge clk);
        rate = 25;
        repeat (1000) @(negedge clk);

        // Reset the CPU-priority instance while it sits in a wait state.
        rate = 60;
        hit  = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge clk);
            if (m_t[1] >= 1 && m_t[1] <= ws_of(1)) hit = 1'b1;
        end
        check("rst_in_wait_reached", 32'(hit), 32'(1));
        rst_k[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_k[1] = 1'b1;
        repeat (1000) @(negedge clk);

        rate = 0;
        repeat (60) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
